itlb_micro_cache: RTL and testbench
===================================

Name: itlb_micro_cache

Overview:
- Small fully-associative micro-TLB that sits directly upstream of the main TLB's registered matcher port (va0 → pa0/hit0/valid0/cached0/error0).
- Serves fetch-stage translations at 4 KB granularity from a local cache.
- On a miss, drives the VA onto the main-TLB matcher, waits for its one-cycle registered result, returns it, and refills locally on success.
- Caches only successful translations; exceptions are always re-walked.

Parameters:
- ENTRIES, 4: number of micro-TLB entries, power of two, ≥2.
- IDX_BITS, $clog2(ENTRIES): entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- flush  in  1  invalidate all entries; parent pulses it on TLBWI, EntryHi.ASID write, kernel_mode/ERL/kseg0-cacheability change
- req_valid  in  1  translation request
- req_va  in  32  virtual address
- req_ready  out  1  request accepted when req_valid&req_ready
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_pa  out  32  physical address
- resp_cached  out  1  cacheable
- resp_exc  out  2  0=OK, 1=ADDR_ERR, 2=REFILL, 3=INVALID
- tlb_va  out  32  VA driven to main-TLB matcher
- tlb_pa  in  32  matcher PA, registered one cycle after tlb_va
- tlb_hit, tlb_valid, tlb_cached, tlb_error  in  1 each  matcher status, same timing
- perf_hit_cnt, perf_miss_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Entry fields: v, vpn[19:0]=va[31:12], ppn[19:0], c. Hit = v && vpn==va_q[31:12]; at most one entry matches by construction.
- Registers: va_q (latched on accept), state, rr_ptr[IDX_BITS-1:0], result registers.
- tlb_va = va_q at all times. The matcher therefore samples va_q every edge; its output reflects the va_q of the previous cycle.
- FSM states: IDLE, CHECK, WAIT, RESP. req_ready = (state==IDLE).
  - IDLE: on accept, va_q<=req_va → CHECK.
  - CHECK: on local hit → RESP with pa={ppn,va_q[11:0]}, cached=c, exc=0. On miss → WAIT.
  - WAIT: matcher outputs now correspond to va_q. Capture pa=tlb_pa, cached=tlb_cached. Exc priority: tlb_error → 1; else !tlb_hit → 2; else !tlb_valid → 3; else 0. If exc==0, refill one entry. → RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready; on resp_ready → IDLE. No new request is accepted in the same cycle.
- Latency (accept edge to resp_valid): hit = 2 cycles; miss = 3 cycles. Throughput is one request at a time.
- Refill victim: lowest-index invalid entry if any. Otherwise entry rr_ptr, then rr_ptr<=rr_ptr+1 (wraps ENTRIES-1 → 0). Refilling an invalid slot does not move rr_ptr.
- Flush:
  - Clears all v bits at the next edge. Flush takes priority over a same-cycle refill: no entry is written.
  - Flush in CHECK or WAIT → next state CHECK. This forces a miss and a fresh main-TLB walk; the stale captured result is discarded.
  - Flush in IDLE or RESP: state unaffected; a pending response is still delivered unchanged.
- Reset (rst==0 at edge): state=IDLE, all v=0, rr_ptr=0, va_q=0, resp_pa=0, resp_cached=0, resp_exc=0, counters=0. Therefore req_ready=1, resp_valid=0, tlb_va=0 after reset. Reset mid-transaction drops the transaction.
- Unmapped-segment results (hit=1, valid=1 from the matcher) are cached like mapped ones. The parent's flush on mode change keeps this correct.

Optional Feature:
- Macro ITLB_MICRO_PERF_CNT_EN.
- Defined: perf_hit_cnt increments on each CHECK→RESP transition; perf_miss_cnt increments on each CHECK→WAIT transition. Both are 32-bit, wrap at 2^32, and are cleared only by reset (not by flush).
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then request va=0x0040_1234 with matcher returning hit=1, valid=1, pa=0x1FC0_1234, cached=1 → resp at accept+3, pa=0x1FC0_1234, exc=0. Same VA again → resp at accept+2 with identical pa, no dependence on tlb_* inputs.
- Miss on va=0x0000_5000 with tlb_hit=0 → exc=2, nothing cached. Repeat with hit=1, valid=0 → exc=3. Repeat with tlb_error=1 and hit=0 → exc=1 (error wins).
- Fill 4 distinct pages (0x1000..0x4000), then a 5th (0x5000) → replaces entry 0. A 6th (0x6000) → replaces entry 1. Re-access 0x1000 → miss (3-cycle latency).
- Cache page 0x1000, then pulse flush during WAIT of a 0x2000 miss → state returns to CHECK, a second matcher walk occurs, the response reflects the tlb_* values after the flush, and 0x1000 then misses.
- Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 → req_ready=0 and resp_pa/resp_exc stable throughout. Drop rst to 0 mid-hold → resp_valid=0 and req_ready=1 after the edge.
- With ITLB_MICRO_PERF_CNT_EN: 3 hits and 2 misses → perf_hit_cnt=3, perf_miss_cnt=2; a flush leaves them unchanged. Without the macro, both read 0.

Source files
------------

// File: rtl/itlb_micro_cache_if.sv
// Request/response and main-TLB matcher signals of the micro-TLB.
// The slave modport is the micro-TLB side; master is the fetch stage plus the matcher.
interface itlb_micro_cache_if;
  logic        req_valid;
  logic [31:0] req_va;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pa;
  logic        resp_cached;
  logic [1:0]  resp_exc;
  logic [31:0] tlb_va;
  logic [31:0] tlb_pa;
  logic        tlb_hit;
  logic        tlb_valid;
  logic        tlb_cached;
  logic        tlb_error;

  modport slave (
    input  req_valid, req_va, resp_ready,
    input  tlb_pa, tlb_hit, tlb_valid, tlb_cached, tlb_error,
    output req_ready, resp_valid, resp_pa, resp_cached, resp_exc, tlb_va
  );

  modport master (
    output req_valid, req_va, resp_ready,
    output tlb_pa, tlb_hit, tlb_valid, tlb_cached, tlb_error,
    input  req_ready, resp_valid, resp_pa, resp_cached, resp_exc, tlb_va
  );
endinterface

// File: rtl/itlb_micro_cache.sv
// Fully-associative fetch micro-TLB in front of the main-TLB registered matcher.
// Optional hit/miss counters are built only when ITLB_MICRO_PERF_CNT_EN is defined.
module itlb_micro_cache #(
  parameter int ENTRIES  = 4,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  itlb_micro_cache_if.slave     bus,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           va_q, va_d;
  logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ENTRIES-1:0]    v_q, v_d;
  logic [19:0]           vpn_q [ENTRIES];
  logic [19:0]           ppn_q [ENTRIES];
  logic [ENTRIES-1:0]    c_q;
  logic [31:0]           pa_q, pa_d;
  logic                  cached_q, cached_d;
  logic [1:0]            exc_q, exc_d;

  logic                  hit_s;
  logic [IDX_BITS-1:0]   hit_idx_s;
  logic                  free_s;
  logic [IDX_BITS-1:0]   free_idx_s;
  logic                  refill_s;
  logic [IDX_BITS-1:0]   victim_s;
  logic [1:0]            walk_exc_s;

  // Matcher status to exception code; an error outranks a missing or invalid mapping.
  function automatic logic [1:0] walk_exc(input logic err, input logic hit, input logic valid);
    logic [1:0] code;
    if (err) begin
      code = 2'd1;
    end else if (!hit) begin
      code = 2'd2;
    end else if (!valid) begin
      code = 2'd3;
    end else begin
      code = 2'd0;
    end
    return code;
  endfunction

  assign walk_exc_s = walk_exc(bus.tlb_error, bus.tlb_hit, bus.tlb_valid);

  // Associative lookup of the latched VA page.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (v_q[i] && (vpn_q[i] == va_q[31:12])) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_BITS'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Lowest-index invalid slot; scanning downward lets the lowest index win.
  always_comb begin
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!v_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = IDX_BITS'(i);
      end else begin
        free_s     = free_s;
        free_idx_s = free_idx_s;
      end
    end
  end

  assign victim_s = free_s ? free_idx_s : rr_ptr_q;

  // Next-state and result capture; a flush in CHECK/WAIT restarts the lookup.
  always_comb begin
    state_d  = state_q;
    va_d     = va_q;
    pa_d     = pa_q;
    cached_d = cached_q;
    exc_d    = exc_q;
    refill_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          va_d    = bus.req_va;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (flush) begin
          state_d = S_CHECK;
        end else if (hit_s) begin
          pa_d     = {ppn_q[hit_idx_s], va_q[11:0]};
          cached_d = c_q[hit_idx_s];
          exc_d    = 2'd0;
          state_d  = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_CHECK;
        end else begin
          pa_d     = bus.tlb_pa;
          cached_d = bus.tlb_cached;
          exc_d    = walk_exc_s;
          refill_s = (walk_exc_s == 2'd0);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Valid bits and round-robin pointer; flush wins over a same-cycle refill.
  always_comb begin
    v_d      = v_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      v_d = '0;
    end else if (refill_s) begin
      v_d[victim_s] = 1'b1;
      if (!free_s) begin
        rr_ptr_d = rr_ptr_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      v_d = v_q;
    end
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      va_q     <= 32'd0;
      rr_ptr_q <= '0;
      v_q      <= '0;
      pa_q     <= 32'd0;
      cached_q <= 1'b0;
      exc_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      va_q     <= va_d;
      rr_ptr_q <= rr_ptr_d;
      v_q      <= v_d;
      pa_q     <= pa_d;
      cached_q <= cached_d;
      exc_q    <= exc_d;
    end
  end

  // Entry payload; only meaningful where the matching v bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (refill_s && !flush) begin
      vpn_q[victim_s] <= va_q[31:12];
      ppn_q[victim_s] <= bus.tlb_pa[31:12];
      c_q[victim_s]   <= bus.tlb_cached;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_pa     = pa_q;
  assign bus.resp_cached = cached_q;
  assign bus.resp_exc    = exc_q;
  assign bus.tlb_va      = va_q;

`ifdef ITLB_MICRO_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counters count CHECK exits only; a flushed CHECK counts as neither.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_CHECK) && (state_d == S_RESP)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else if ((state_q == S_CHECK) && (state_d == S_WAIT)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = 32'd0;
  assign perf_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_itlb_micro_cache.sv
// Directed bench for itlb_micro_cache: hit/miss latency, exception codes,
// replacement order, flush restart, response hold, reset and perf counters.
module tb_itlb_micro_cache;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
  int          checks_cnt;
  int          errors_cnt;

  itlb_micro_cache_if bus();

  itlb_micro_cache #(.ENTRIES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus.slave),
    .perf_hit_cnt (perf_hit_cnt),
    .perf_miss_cnt(perf_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tlb(input logic [31:0] pa, input logic hit, input logic valid,
                         input logic cached, input logic err);
    bus.tlb_pa     = pa;
    bus.tlb_hit    = hit;
    bus.tlb_valid  = valid;
    bus.tlb_cached = cached;
    bus.tlb_error  = err;
  endtask

  // lat is the edge (counted from the accept edge) at which resp_valid is first sampled high.
  task automatic req_chk(input string tag, input logic [31:0] va, input logic [31:0] exp_pa,
                         input logic exp_c, input logic [1:0] exp_exc, input int exp_lat);
    int n;
    check({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_va    = va;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 16) begin
      tick();
      n++;
    end
    check({tag, ".resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    check({tag, ".lat"}, n + 1, exp_lat);
    check({tag, ".pa"}, bus.resp_pa, exp_pa);
    check({tag, ".cached"}, {31'd0, bus.resp_cached}, {31'd0, exp_c});
    check({tag, ".exc"}, {30'd0, bus.resp_exc}, {30'd0, exp_exc});
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pa;
    logic [1:0]  held_exc;
    int          n;
    checks_cnt     = 0;
    errors_cnt     = 0;
    rst            = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_va     = 32'd0;
    bus.resp_ready = 1'b0;
    set_tlb(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.tlb_va", bus.tlb_va, 32'd0);
    check("rst.resp_pa", bus.resp_pa, 32'd0);
    check("rst.perf_hit", perf_hit_cnt, 32'd0);
    check("rst.perf_miss", perf_miss_cnt, 32'd0);

    // first access walks, second hits without looking at the matcher
    set_tlb(32'h1FC0_1234, 1'b1, 1'b1, 1'b1, 1'b0);
    req_chk("miss1", 32'h0040_1234, 32'h1FC0_1234, 1'b1, 2'd0, 3);
    set_tlb(32'hDEAD_B000, 1'b0, 1'b0, 1'b0, 1'b1);
    req_chk("hit1", 32'h0040_1234, 32'h1FC0_1234, 1'b1, 2'd0, 2);

    // exceptions are never cached
    set_tlb(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    req_chk("exc_refill", 32'h0000_5000, 32'h0000_0000, 1'b0, 2'd2, 3);
    set_tlb(32'h0012_3000, 1'b1, 1'b0, 1'b1, 1'b0);
    req_chk("exc_invalid", 32'h0000_5000, 32'h0012_3000, 1'b1, 2'd3, 3);
    set_tlb(32'h0045_6000, 1'b0, 1'b0, 1'b0, 1'b1);
    req_chk("exc_addr", 32'h0000_5000, 32'h0045_6000, 1'b0, 2'd1, 3);

    // replacement: invalid slots first, then round robin from entry 0
    pulse_flush();
    for (int p = 1; p <= 6; p++) begin
      set_tlb(32'h8000_0000 | (p << 12), 1'b1, 1'b1, 1'b0, 1'b0);
      req_chk("fill", p << 12, 32'h8000_0000 | (p << 12), 1'b0, 2'd0, 3);
    end
    set_tlb(32'hDEAD_B000, 1'b0, 1'b0, 1'b0, 1'b1);
    req_chk("keep3", 32'h0000_3ABC, 32'h8000_3ABC, 1'b0, 2'd0, 2);
    set_tlb(32'h9000_1000, 1'b1, 1'b1, 1'b1, 1'b0);
    req_chk("evict1", 32'h0000_1000, 32'h9000_1000, 1'b1, 2'd0, 3);
    set_tlb(32'hDEAD_B000, 1'b0, 1'b0, 1'b0, 1'b1);
    req_chk("keep4", 32'h0000_4000, 32'h8000_4000, 1'b0, 2'd0, 2);
    req_chk("hit1b", 32'h0000_1004, 32'h9000_1004, 1'b1, 2'd0, 2);
    set_tlb(32'h9000_2000, 1'b1, 1'b1, 1'b0, 1'b0);
    req_chk("evict2", 32'h0000_2000, 32'h9000_2000, 1'b0, 2'd0, 3);
    set_tlb(32'h9000_4000, 1'b1, 1'b1, 1'b0, 1'b0);
    req_chk("evict4", 32'h0000_4000, 32'h9000_4000, 1'b0, 2'd0, 3);

    // flush during WAIT restarts the walk and drops the stale capture
    pulse_flush();
    set_tlb(32'hA000_1000, 1'b1, 1'b1, 1'b1, 1'b0);
    req_chk("fl.fill", 32'h0000_1000, 32'hA000_1000, 1'b1, 2'd0, 3);
    set_tlb(32'hB000_2000, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_va    = 32'h0000_2000;
    tick();
    bus.req_valid = 1'b0;
    tick();
    flush = 1'b1;
    set_tlb(32'hC000_2000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    check("fl.no_resp0", {31'd0, bus.resp_valid}, 32'd0);
    check("fl.tlb_va", bus.tlb_va, 32'h0000_2000);
    tick();
    check("fl.no_resp1", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    check("fl.resp", {31'd0, bus.resp_valid}, 32'd1);
    check("fl.pa", bus.resp_pa, 32'hC000_2000);
    check("fl.cached", {31'd0, bus.resp_cached}, 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    set_tlb(32'hA100_1000, 1'b1, 1'b1, 1'b0, 1'b0);
    req_chk("fl.remiss", 32'h0000_1000, 32'hA100_1000, 1'b0, 2'd0, 3);

    // response held under back-pressure with a pending request, then reset
    set_tlb(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_va    = 32'h0000_7000;
    tick();
    bus.req_va    = 32'h0000_8000;
    n = 0;
    while (!bus.resp_valid && n < 16) begin
      tick();
      n++;
    end
    check("hold.resp", {31'd0, bus.resp_valid}, 32'd1);
    held_pa  = bus.resp_pa;
    held_exc = bus.resp_exc;
    check("hold.exc0", {30'd0, held_exc}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold.req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("hold.resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold.pa", bus.resp_pa, held_pa);
      check("hold.exc", {30'd0, bus.resp_exc}, {30'd0, held_exc});
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("mrst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mrst.tlb_va", bus.tlb_va, 32'd0);

    // 2 misses then 3 hits, then a flush that must not touch the counters
    set_tlb(32'h5000_1000, 1'b1, 1'b1, 1'b1, 1'b0);
    req_chk("pc.m1", 32'h0000_1000, 32'h5000_1000, 1'b1, 2'd0, 3);
    set_tlb(32'h5000_2000, 1'b1, 1'b1, 1'b1, 1'b0);
    req_chk("pc.m2", 32'h0000_2000, 32'h5000_2000, 1'b1, 2'd0, 3);
    req_chk("pc.h1", 32'h0000_1010, 32'h5000_1010, 1'b1, 2'd0, 2);
    req_chk("pc.h2", 32'h0000_2020, 32'h5000_2020, 1'b1, 2'd0, 2);
    req_chk("pc.h3", 32'h0000_1030, 32'h5000_1030, 1'b1, 2'd0, 2);
    pulse_flush();
`ifdef ITLB_MICRO_PERF_CNT_EN
    check("perf.hit", perf_hit_cnt, 32'd3);
    check("perf.miss", perf_miss_cnt, 32'd2);
`else
    check("perf.hit", perf_hit_cnt, 32'd0);
    check("perf.miss", perf_miss_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
